// File: rtl/sdram_arb_pkg.sv
// Shared types and default constants for the SDRAM port arbiter.
// Command fields are sized to the 64 MB x16 controller slave.
package sdram_arb_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 25;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_PEND = 8;

    localparam int CMD_ADDR_W = DEF_ADDR_W;
    localparam int CMD_DATA_W = DEF_DATA_W;
    localparam int CMD_BE_W   = CMD_DATA_W / 8;

    typedef enum logic {
        IDLE,
        ISSUE
    } cmd_state_t;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] address;
        logic [CMD_DATA_W-1:0] writedata;
        logic [CMD_BE_W-1:0]   byteenable;
        logic                  read;
        logic                  write;
    } cmd_t;

    // Requester index reached k steps after base, wrapping at n.
    function automatic int rr_next(input int base, input int k, input int n);
        int idx;
        idx = base + k;
        if (idx >= n) idx = idx - n;
        return idx;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Synchronous FIFO of requester IDs for outstanding reads; a push and a
// pop may happen in the same cycle even when the FIFO is full.
module sdram_arb_tag_fifo #(
    parameter int ID_W  = 2,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_push,
    input  logic [ID_W-1:0] i_id,
    input  logic            i_pop,
    output logic [ID_W-1:0] o_head,
    output logic            o_full,
    output logic            o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // NOTE: storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_id;
    end

    // NOTE: all state in clocked blocks uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM slave among NUM_REQ masters.
// Define SDRAM_ARB_LOCK_EN to add req_lock, which lets the last winner hold the port.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_address,
    input  logic [NUM_REQ-1:0]                req_read,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_writedata,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]  req_byteenable,
`ifdef SDRAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]                req_lock,
`endif
    output logic [NUM_REQ-1:0]                req_waitrequest,
    output logic [DATA_W-1:0]                 req_readdata,
    output logic [NUM_REQ-1:0]                req_readdatavalid,
    output logic [ADDR_W-1:0]                 m_address,
    output logic                              m_read,
    output logic                              m_write,
    output logic [DATA_W-1:0]                 m_writedata,
    output logic [DATA_W/8-1:0]               m_byteenable,
    input  logic                              m_waitrequest,
    input  logic [DATA_W-1:0]                 m_readdata,
    input  logic                              m_readdatavalid,
    output logic                              err_unexp_rdv
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BE_W = DATA_W / 8;

    cmd_state_t        r_state;
    cmd_t              r_cmd;
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_err;

    logic              w_free;
    logic              w_pop;
    logic              w_found;
    logic              w_grant;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ID_W-1:0]   w_win;
    logic [ID_W-1:0]   w_head;
    logic [NUM_REQ-1:0] w_elig;
    cmd_t              w_win_cmd;

    assign w_free  = (r_state == IDLE) || !m_waitrequest;
    assign w_pop   = reset_n && m_readdatavalid && !w_fifo_empty;
    assign w_grant = reset_n && w_free && w_found;

    // A read needs a free tag slot, which a same-cycle return also provides.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_read[i] ? (!w_fifo_full || w_pop) : req_write[i];
        end
`ifdef SDRAM_ARB_LOCK_EN
        if (req_lock[r_rr_ptr]) w_elig = w_elig & (NUM_REQ'(1) << r_rr_ptr);
`endif
    end

    // NOTE: combinational blocks use blocking assignments so the search sees its own updates.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = rr_next(int'(r_rr_ptr), k, NUM_REQ);
            if (!w_found && w_elig[ID_W'(idx)]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_win_cmd            = '0;
        w_win_cmd.address    = CMD_ADDR_W'(req_address[w_win]);
        w_win_cmd.writedata  = CMD_DATA_W'(req_writedata[w_win]);
        w_win_cmd.byteenable = CMD_BE_W'(req_byteenable[w_win]);
        w_win_cmd.read       = req_read[w_win];
        w_win_cmd.write      = req_write[w_win] & ~req_read[w_win];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cmd    <= '0;
            r_rr_ptr <= ID_W'(NUM_REQ - 1);
            r_err    <= 1'b0;
        end else begin
            if (w_free) begin
                if (w_found) begin
                    r_cmd    <= w_win_cmd;
                    r_rr_ptr <= w_win;
                    r_state  <= ISSUE;
                end else begin
                    r_cmd.read  <= 1'b0;
                    r_cmd.write <= 1'b0;
                    r_state     <= IDLE;
                end
            end
            if (m_readdatavalid && w_fifo_empty) r_err <= 1'b1;
        end
    end

    sdram_arb_tag_fifo #(
        .ID_W  (ID_W),
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_grant && w_win_cmd.read),
        .i_id    (w_win),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign req_waitrequest   = w_grant ? ~(NUM_REQ'(1) << w_win) : '1;
    assign req_readdatavalid = w_pop ? (NUM_REQ'(1) << w_head) : '0;
    assign req_readdata      = m_readdata;

    assign m_address     = ADDR_W'(r_cmd.address);
    assign m_writedata   = DATA_W'(r_cmd.writedata);
    assign m_byteenable  = BE_W'(r_cmd.byteenable);
    assign m_read        = r_cmd.read;
    assign m_write       = r_cmd.write;
    assign err_unexp_rdv = r_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a vector table for single-cycle
// arbitration plus hand sequences for stalls, tag routing and reset.
module tb_sdram_port_arbiter;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0][24:0] req_address;
    logic [3:0]       req_read;
    logic [3:0]       req_write;
    logic [3:0][15:0] req_writedata;
    logic [3:0][1:0]  req_byteenable;
    logic [3:0]       req_waitrequest;
    logic [15:0]      req_readdata;
    logic [3:0]       req_readdatavalid;
    logic [24:0]      m_address;
    logic             m_read;
    logic             m_write;
    logic [15:0]      m_writedata;
    logic [1:0]       m_byteenable;
    logic             m_waitrequest;
    logic [15:0]      m_readdata;
    logic             m_readdatavalid;
    logic             err_unexp_rdv;

    int n_tests;
    int n_fail;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NUM_REQ  (4),
        .ADDR_W   (25),
        .DATA_W   (16),
        .MAX_PEND (8)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_address       (req_address),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_writedata     (req_writedata),
        .req_byteenable    (req_byteenable),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .m_address         (m_address),
        .m_read            (m_read),
        .m_write           (m_write),
        .m_writedata       (m_writedata),
        .m_byteenable      (m_byteenable),
        .m_waitrequest     (m_waitrequest),
        .m_readdata        (m_readdata),
        .m_readdatavalid   (m_readdatavalid),
        .err_unexp_rdv     (err_unexp_rdv)
    );

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic       mw;
        logic [3:0] ew;
        logic       er;
        logic       ewr;
        int         ep;
    } vec_t;

    vec_t tbl [13];

    // Per-port command payload; port -1 stands for the all-zero reset command.
    function automatic logic [24:0] pa(input int p);
        return (p < 0) ? 25'h0 : 25'h0001000 + 25'(p);
    endfunction
    function automatic logic [15:0] pd(input int p);
        return (p < 0) ? 16'h0 : 16'hA000 + 16'(p);
    endfunction
    function automatic logic [1:0] pb(input int p);
        if (p < 0) return 2'b00;
        return (p % 2 == 0) ? 2'b11 : 2'b10;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cmd(input string name, input logic er, input logic ew, input int p);
        check(name, {m_read, m_write, m_address, m_writedata, m_byteenable},
                    {er, ew, pa(p), pd(p), pb(p)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_read        = '0;
        req_write       = '0;
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        reset_n         = 1'b0;
        tick();
        reset_n         = 1'b1;
    endtask

    logic [3:0] exp_w;
    logic [3:0] s5_exp [3];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int p = 0; p < 4; p++) begin
            req_address[p]    = pa(p);
            req_writedata[p]  = pd(p);
            req_byteenable[p] = pb(p);
        end
        //          rd       wr       mw    ew       er    ewr   ep
        tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, -1};
        tbl[1]  = '{4'b0000, 4'b1111, 1'b0, 4'b1110, 1'b0, 1'b1, 0};
        tbl[2]  = '{4'b0000, 4'b1111, 1'b0, 4'b1101, 1'b0, 1'b1, 1};
        tbl[3]  = '{4'b0000, 4'b1111, 1'b1, 4'b1111, 1'b0, 1'b1, 1};
        tbl[4]  = '{4'b0000, 4'b1011, 1'b0, 4'b0111, 1'b0, 1'b1, 3};
        tbl[5]  = '{4'b0000, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b1, 0};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 0};
        tbl[7]  = '{4'b0100, 4'b0000, 1'b0, 4'b1011, 1'b1, 1'b0, 2};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 2};
        tbl[9]  = '{4'b0000, 4'b0010, 1'b0, 4'b1101, 1'b0, 1'b1, 1};
        tbl[10] = '{4'b0001, 4'b0100, 1'b0, 4'b1011, 1'b0, 1'b1, 2};
        tbl[11] = '{4'b0001, 4'b0000, 1'b0, 4'b1110, 1'b1, 1'b0, 0};
        tbl[12] = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 0};
        s5_exp[0] = 4'b1000;
        s5_exp[1] = 4'b0001;
        s5_exp[2] = 4'b1000;

        do_reset();
        check("rst_wait", req_waitrequest, 4'b1111);
        check("rst_rdv", req_readdatavalid, 4'b0000);
        check("rst_err", err_unexp_rdv, 1'b0);
        check_cmd("rst_cmd", 1'b0, 1'b0, -1);

        for (int i = 0; i < 13; i++) begin
            req_read      = tbl[i].rd;
            req_write     = tbl[i].wr;
            m_waitrequest = tbl[i].mw;
            #1;
            check($sformatf("vec%0d_wait", i), req_waitrequest, tbl[i].ew);
            tick();
            check_cmd($sformatf("vec%0d_cmd", i), tbl[i].er, tbl[i].ewr, tbl[i].ep);
        end

        // Single read from port 2, controller latency 3.
        do_reset();
        req_address[2] = 25'h0001234;
        req_read = 4'b0100;
        #1;
        check("s1_grant", req_waitrequest, 4'b1011);
        tick();
        req_read = '0;
        check("s1_mread", {m_read, m_write, m_address}, {1'b1, 1'b0, 25'h0001234});
        tick();
        check("s1_mread_drop", {m_read, req_readdatavalid}, 5'b0);
        tick();
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 16'hBEEF;
        #1;
        check("s1_rdv", req_readdatavalid, 4'b0100);
        check("s1_rdata", req_readdata, 16'hBEEF);
        tick();
        m_readdatavalid = 1'b0;
        req_address[2] = pa(2);

        // All ports writing continuously: strict rotation, one write per clock.
        do_reset();
        req_write = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_w = ~(4'b0001 << (k % 4));
            #1;
            check("s2_wait", req_waitrequest, exp_w);
            tick();
            check_cmd("s2_cmd", 1'b0, 1'b1, k % 4);
        end
        req_write = '0;

        // Tag FIFO full: 9th read held, write still passes, a return frees it.
        do_reset();
        req_read = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("s3_cap", req_waitrequest[1], 1'b0);
            tick();
        end
        #1;
        check("s3_hold", req_waitrequest, 4'b1111);
        req_write = 4'b0001;
        #1;
        check("s3_wr_grant", req_waitrequest, 4'b1110);
        tick();
        req_write = '0;
        check_cmd("s3_wr_cmd", 1'b0, 1'b1, 0);
        #1;
        check("s3_still_hold", req_waitrequest, 4'b1111);
        m_readdatavalid = 1'b1;
        m_readdata = 16'h0011;
        #1;
        check("s3_ret_rdv", req_readdatavalid, 4'b0010);
        check("s3_release", req_waitrequest, 4'b1101);
        tick();
        m_readdatavalid = 1'b0;
        req_read = '0;
        check_cmd("s3_rd9_cmd", 1'b1, 1'b0, 1);

        // Controller stall of 5 cycles during a write.
        do_reset();
        req_write = 4'b0100;
        #1;
        check("s4_grant", req_waitrequest, 4'b1011);
        tick();
        req_write = 4'b1011;
        m_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("s4_stall_wait", req_waitrequest, 4'b1111);
            check_cmd("s4_stall_cmd", 1'b0, 1'b1, 2);
            tick();
        end
        m_waitrequest = 1'b0;
        #1;
        check("s4_accept_wait", req_waitrequest, 4'b0111);
        tick();
        req_write = '0;
        check_cmd("s4_next_cmd", 1'b0, 1'b1, 3);

        // Interleaved reads 3,0,3 return in order; a stray return flags an error.
        do_reset();
        req_read = 4'b1000;
        #1;
        check("s5_g0", req_waitrequest, 4'b0111);
        tick();
        req_read = 4'b0001;
        #1;
        check("s5_g1", req_waitrequest, 4'b1110);
        tick();
        req_read = 4'b1000;
        #1;
        check("s5_g2", req_waitrequest, 4'b0111);
        tick();
        req_read = '0;
        for (int k = 0; k < 3; k++) begin
            m_readdatavalid = 1'b1;
            m_readdata = 16'h5A00 + 16'(k);
            #1;
            check("s5_rdv", req_readdatavalid, s5_exp[k]);
            check("s5_rdata", req_readdata, 16'h5A00 + 16'(k));
            tick();
        end
        check("s5_err_clear", err_unexp_rdv, 1'b0);
        #1;
        check("s5_stray_rdv", req_readdatavalid, 4'b0000);
        tick();
        m_readdatavalid = 1'b0;
        check("s5_err_set", err_unexp_rdv, 1'b1);
        tick();
        check("s5_err_sticky", err_unexp_rdv, 1'b1);

        // Reset with 4 reads outstanding.
        do_reset();
        req_read = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("s6_cap", req_waitrequest[1], 1'b0);
            tick();
        end
        req_read = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_cmd("s6_cmd", 1'b0, 1'b0, -1);
        check("s6_wait", req_waitrequest, 4'b1111);
        check("s6_err", err_unexp_rdv, 1'b0);
        m_readdatavalid = 1'b1;
        #1;
        check("s6_fifo_empty", req_readdatavalid, 4'b0000);
        tick();
        m_readdatavalid = 1'b0;
        req_read = 4'b1111;
        #1;
        check("s6_port0_first", req_waitrequest, 4'b1110);
        tick();
        req_read = '0;
        check_cmd("s6_first_cmd", 1'b1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single Avalon-MM slave of the FPGA-side SDRAM controller (64 MB, 16-bit, 25-bit word address) between NUM_REQ fabric masters. It sits between the accelerator datapath engines and the SDRAM controller port inside the system. It uses round-robin arbitration with a one-entry registered command stage. A tag FIFO routes pipelined read data back to the requester that issued the read.

## Interface
Parameters:
- NUM_REQ, 4, number of requester ports (2..8)
- ADDR_W, 25, word address width
- DATA_W, 16, data width; byteenable width is DATA_W/8
- MAX_PEND, 8, maximum outstanding reads (power of two, ≥2)

Ports:
- clk  in  1  system clock (same domain as the SDRAM controller slave)
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- req_address  in  [NUM_REQ][ADDR_W]  per-requester word address
- req_read, req_write  in  [NUM_REQ]  per-requester command strobes (mutually exclusive per port)
- req_writedata  in  [NUM_REQ][DATA_W]  write data
- req_byteenable  in  [NUM_REQ][DATA_W/8]  byte enables
- req_waitrequest  out  [NUM_REQ]  low = command captured this cycle
- req_readdata  out  DATA_W  broadcast read data
- req_readdatavalid  out  [NUM_REQ]  one-hot read return strobe
- m_address, m_read, m_write, m_writedata, m_byteenable  out  matching widths  registered command to the controller
- m_waitrequest  in  1  controller stall
- m_readdata  in  DATA_W, m_readdatavalid  in  1  pipelined read return
- err_unexp_rdv  out  1  sticky: readdatavalid arrived with no outstanding read

## Operation
- Command stage states: IDLE (buffer empty) and ISSUE (m_read or m_write high, waiting for controller).
- Buffer "free" = IDLE, or ISSUE with m_waitrequest low this cycle.
- Eligible requester: read|write high. A read is eligible only if the tag FIFO is not full, or a pop occurs this cycle.
- When the buffer is free, the winner is the first eligible requester, searching from rr_ptr+1 modulo NUM_REQ.
  - Winner's req_waitrequest goes low combinationally that cycle.
  - Its command is registered into m_*; rr_ptr <= winner; state -> ISSUE.
  - A read pushes the winner ID into the tag FIFO.
- No winner while the buffer is free: m_read/m_write <= 0; state -> IDLE.
- req_waitrequest is high for every non-winner, always.
- Read return: m_readdatavalid pops the FIFO head.
  - req_readdatavalid[head] = 1 in the same cycle, combinationally.
  - req_readdata = m_readdata, unregistered.
- Pop with FIFO empty: no strobe; err_unexp_rdv <= 1 until reset.
- Simultaneous push and pop on a full FIFO is permitted; occupancy is unchanged.
- Writes never touch the FIFO and are not blocked by FIFO-full.
- Reset values:
  - m_read, m_write: 0; m_address, m_writedata, m_byteenable: 0
  - req_waitrequest: all 1; req_readdatavalid: 0; err_unexp_rdv: 0
  - rr_ptr: NUM_REQ-1, so port 0 wins first
  - FIFO: empty
- Reset mid-operation drops the issued command and all outstanding tags. The controller is reset by the same reset_n.

## Timing
- Capture: requester command in cycle N -> m_* valid in cycle N+1.
- Back-to-back: a new command is captured in the same cycle m_waitrequest is low. Sustained throughput is one command per clock.
- Read data: zero added latency. The controller's readdatavalid cycle is the requester's readdatavalid cycle.
- Fairness: an eligible requester waits at most NUM_REQ-1 other grants.

## Configuration
- SDRAM_ARB_LOCK_EN defined:
  - Adds input req_lock [NUM_REQ].
  - If requester rr_ptr has req_lock high, only that requester is eligible, including while it is idle. All others stall until the lock drops.
- SDRAM_ARB_LOCK_EN undefined:
  - No req_lock port.
  - Pure round-robin.

## Structure
- Package sdram_arb_pkg holds:
  - default parameter constants
  - cmd_state_t enum {IDLE, ISSUE}
  - a cmd_t struct (address, writedata, byteenable, read, write)
- Sub-module sdram_arb_tag_fifo:
  - synchronous FIFO of $clog2(NUM_REQ)-bit IDs, MAX_PEND deep
  - full/empty flags; same-cycle push+pop allowed

## Test plan
- Single read, port 2, address 0x0001234, controller latency 3: m_read high 1 cycle after capture; req_readdatavalid = 4'b0100 with data 0xBEEF.
- All 4 ports write continuously with m_waitrequest low: grant order 0,1,2,3,0…; exactly one m_write per clock.
- 9 reads from port 1 with readdatavalid withheld: 8 captured; 9th held (waitrequest high); a write from port 0 still issues; the first return releases the 9th read.
- m_waitrequest high 5 cycles during a write: m_* stable throughout; no other port captured; accepted on cycle 6.
- Interleaved reads from ports 3, 0, 3: returns strobe ports 3, 0, 3 in order. A stray m_readdatavalid afterwards sets err_unexp_rdv.
- reset_n low for 1 cycle with 4 reads outstanding: all outputs at reset values next cycle; FIFO empty; port 0 wins the next arbitration.
